// File: rtl/dbp_block_builder_if.sv
// Shared EBPC widths and block type, plus the word-in / block-out bundle
// used by the block builder.
package ebpc_pkg;
  localparam int DATA_W     = 8;
  localparam int BLOCK_SIZE = 8;
  localparam int CNT_W      = (BLOCK_SIZE > 2) ? $clog2(BLOCK_SIZE) : 1;

  typedef struct packed {
    logic [DATA_W-1:0]                 base;
    logic [DATA_W:0][BLOCK_SIZE-2:0]   dbp;
    logic                              flush;
  } dbp_block_t;
endpackage

interface dbp_block_builder_if;
  import ebpc_pkg::*;

  logic [DATA_W-1:0] data_i;
  logic              flush_i;
  logic              vld_i;
  logic              rdy_o;
  dbp_block_t        dbp_block_o;
  logic              vld_o;
  logic              rdy_i;
  logic              idle_o;

  modport slave (
    input  data_i, flush_i, vld_i, rdy_i,
    output rdy_o, dbp_block_o, vld_o, idle_o
  );

  modport master (
    output data_i, flush_i, vld_i, rdy_i,
    input  rdy_o, dbp_block_o, vld_o, idle_o
  );
endinterface

// File: rtl/dbp_block_builder.sv
// Collects words into blocks, forms base + consecutive deltas, and presents
// the deltas transposed into bit-planes for the downstream bit-plane coder.
module dbp_block_builder
  import ebpc_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dbp_block_builder_if.slave   bus_if
);

  typedef enum logic {COLLECT, OUT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic              flush_q, flush_d;

  logic              accept;
  logic              hs_out;
  logic              last_word;
  logic [DATA_W:0]   x_ext;
  logic [DATA_W:0]   prev_ext;
  logic [DATA_W:0]   delta;
  logic [DATA_W:0]   neg_x;

  logic [DATA_W:0][BLOCK_SIZE-2:0] dbp_w;

  assign accept    = (state_q == COLLECT) && bus_if.vld_i;
  assign hs_out    = (state_q == OUT) && bus_if.rdy_i;
  assign last_word = (cnt_q == CNT_W'(BLOCK_SIZE-1));

  // One extra bit keeps the difference of two signed words exact.
  assign x_ext    = {bus_if.data_i[DATA_W-1], bus_if.data_i};
  assign prev_ext = {prev_q[DATA_W-1], prev_q};
  assign delta    = x_ext - prev_ext;
  assign neg_x    = (DATA_W+1)'(0) - x_ext;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      prev_q  <= '0;
      base_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      base_q  <= base_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    base_d  = base_q;
    flush_d = flush_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          prev_d = bus_if.data_i;
          if (cnt_q == '0) begin
            base_d = bus_if.data_i;
          end
          if (last_word || bus_if.flush_i) begin
            cnt_d   = '0;
            flush_d = bus_if.flush_i;
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (bus_if.rdy_i) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Deltas are stored column-wise (one register per delta) and transposed
  // into bit-planes only on the output wiring.
  genvar gi, gj;
  generate
    for (gi = 0; gi < BLOCK_SIZE-1; gi++) begin : g_col
      logic [DATA_W:0] col_q, col_d;

      always_comb begin
        col_d = col_q;
        if (hs_out) begin
          col_d = '0;
        end else if (accept) begin
          if (cnt_q == CNT_W'(gi+1)) begin
            col_d = delta;
          end else if (bus_if.flush_i && (cnt_q == CNT_W'(gi))) begin
            // Virtual zero padding: the step from x down to 0.
            col_d = neg_x;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          col_q <= '0;
        end else begin
          col_q <= col_d;
        end
      end

      for (gj = 0; gj <= DATA_W; gj++) begin : g_bit
        assign dbp_w[gj][gi] = col_q[gj];
      end
    end
  endgenerate

  assign bus_if.dbp_block_o = {base_q, dbp_w, flush_q};
  assign bus_if.vld_o       = (state_q == OUT);
  assign bus_if.rdy_o       = (state_q == COLLECT);
  assign bus_if.idle_o      = (state_q == COLLECT) && (cnt_q == '0);

endmodule

// File: tb/tb_dbp_block_builder.sv
// Scoreboard bench for dbp_block_builder: a padded-word reference model
// predicts each block when its words are accepted; blocks are compared at handshake.
module tb_dbp_block_builder;
  import ebpc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dbp_block_builder_if bus_if ();

  dbp_block_builder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_blocks = 0;

  dbp_block_t        exp_q[$];
  logic [DATA_W-1:0] cur_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W:0] col_of(input dbp_block_t b, input int c);
    logic [DATA_W:0] r;
    for (int j = 0; j <= DATA_W; j++) r[j] = b.dbp[j][c];
    return r;
  endfunction

  // Words past the end of a flushed block count as zero.
  function automatic int word_at(input int k);
    int v;
    if (k < cur_q.size()) v = $signed(cur_q[k]);
    else v = 0;
    return v;
  endfunction

  function automatic dbp_block_t build(input logic f);
    dbp_block_t b;
    int d;
    b.base  = cur_q[0];
    b.flush = f;
    for (int k = 1; k < BLOCK_SIZE; k++) begin
      d = word_at(k) - word_at(k-1);
      for (int j = 0; j <= DATA_W; j++) b.dbp[j][k-1] = d[j];
    end
    return b;
  endfunction

  task automatic model_accept(input logic [DATA_W-1:0] x, input logic f);
    cur_q.push_back(x);
    if (f || cur_q.size() == BLOCK_SIZE) begin
      exp_q.push_back(build(f));
      cur_q.delete();
    end
  endtask

  // Called at a falling edge with inputs already set; books what the next
  // rising edge will transfer, then advances one cycle.
  task automatic cycle();
    dbp_block_t e;
    if (bus_if.vld_i && bus_if.rdy_o) model_accept(bus_if.data_i, bus_if.flush_i);
    if (bus_if.vld_o && bus_if.rdy_i) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_blk", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("blk_base", bus_if.dbp_block_o.base, e.base);
        check_eq("blk_dbp", bus_if.dbp_block_o.dbp, e.dbp);
        check_eq("blk_flush", bus_if.dbp_block_o.flush, e.flush);
        $display("blk %0d base=%0d flush=%0b dbp=%0h", n_blocks,
                 $signed(bus_if.dbp_block_o.base), bus_if.dbp_block_o.flush,
                 bus_if.dbp_block_o.dbp);
        n_blocks++;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic f);
    bit done = 0;
    bus_if.vld_i   = 1'b1;
    bus_if.data_i  = x;
    bus_if.flush_i = f;
    for (int t = 0; t < 100; t++) begin
      if (bus_if.rdy_o) begin
        cycle();
        done = 1;
        break;
      end
      cycle();
    end
    if (!done) check_eq("send_timeout", 0, 1);
    bus_if.vld_i   = 1'b0;
    bus_if.flush_i = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bus_if.rdy_i = 1'b1;
    for (int t = 0; t < max_cycles; t++) begin
      if (exp_q.size() == 0 && !bus_if.vld_o) break;
      cycle();
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bus_if.vld_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_vld_o", bus_if.vld_o, 0);
    check_eq("rst_rdy_o", bus_if.rdy_o, 1);
    check_eq("rst_idle_o", bus_if.idle_o, 1);
    exp_q.delete();
    cur_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1[8] = '{10, 12, 12, 11, 11, 11, 11, 11};
    logic [DATA_W-1:0] word;
    dbp_block_t snap;

    rst_n          = 1'b0;
    bus_if.vld_i   = 1'b0;
    bus_if.data_i  = '0;
    bus_if.flush_i = 1'b0;
    bus_if.rdy_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_vld_o", bus_if.vld_o, 0);
    check_eq("reset_rdy_o", bus_if.rdy_o, 1);
    check_eq("reset_idle_o", bus_if.idle_o, 1);
    check_eq("reset_block", bus_if.dbp_block_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full block, no stall
    for (int i = 0; i < 8; i++) begin
      word = w1[i][DATA_W-1:0];
      send(word, 1'b0);
    end
    check_eq("full_vld_o", bus_if.vld_o, 1);
    check_eq("full_base", bus_if.dbp_block_o.base, 10);
    check_eq("full_dbp0", bus_if.dbp_block_o.dbp[0], 7'b0000100);
    check_eq("full_dbp1", bus_if.dbp_block_o.dbp[1], 7'b0000101);
    check_eq("full_dbp8", bus_if.dbp_block_o.dbp[8], 7'b0000100);
    check_eq("full_flush", bus_if.dbp_block_o.flush, 0);
    cycle();
    check_eq("full_vld_drop", bus_if.vld_o, 0);
    check_eq("full_idle", bus_if.idle_o, 1);

    // Extreme range
    send(8'h80, 1'b0);
    for (int i = 0; i < 7; i++) send(8'h7F, 1'b0);
    check_eq("ext_pos_d1", col_of(bus_if.dbp_block_o, 0), 9'h0FF);
    cycle();
    send(8'h7F, 1'b0);
    for (int i = 0; i < 7; i++) send(8'h80, 1'b0);
    check_eq("ext_neg_d1", col_of(bus_if.dbp_block_o, 0), 9'h101);
    cycle();

    // Partial flush
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    check_eq("pf_vld_o", bus_if.vld_o, 1);
    check_eq("pf_base", bus_if.dbp_block_o.base, 5);
    check_eq("pf_d1", col_of(bus_if.dbp_block_o, 0), 9'h002);
    check_eq("pf_d2", col_of(bus_if.dbp_block_o, 1), 9'h1F9);
    check_eq("pf_d3", col_of(bus_if.dbp_block_o, 2), 9'h000);
    check_eq("pf_flush", bus_if.dbp_block_o.flush, 1);
    cycle();
    check_eq("pf_idle", bus_if.idle_o, 1);

    // Flush on the first word
    send(8'd3, 1'b1);
    check_eq("f1_base", bus_if.dbp_block_o.base, 3);
    check_eq("f1_d1", col_of(bus_if.dbp_block_o, 0), 9'h1FD);
    check_eq("f1_d2", col_of(bus_if.dbp_block_o, 1), 9'h000);
    check_eq("f1_flush", bus_if.dbp_block_o.flush, 1);
    cycle();

    // Backpressure
    bus_if.rdy_i = 1'b0;
    for (int i = 0; i < 8; i++) send(DATA_W'($urandom), 1'b0);
    snap = bus_if.dbp_block_o;
    for (int t = 0; t < 20; t++) begin
      check_eq("bp_vld_o", bus_if.vld_o, 1);
      check_eq("bp_rdy_o", bus_if.rdy_o, 0);
      check_eq("bp_stable", bus_if.dbp_block_o, snap);
      cycle();
    end
    bus_if.rdy_i   = 1'b1;
    bus_if.vld_i   = 1'b1;
    bus_if.data_i  = 8'd42;
    check_eq("bp_hs_rdy_o", bus_if.rdy_o, 0);
    cycle();
    check_eq("bp_after_rdy_o", bus_if.rdy_o, 1);
    check_eq("bp_after_vld_o", bus_if.vld_o, 0);
    send(8'd42, 1'b0);
    for (int i = 1; i < 8; i++) send(DATA_W'($urandom), 1'b0);
    drain(20);

    // Random back-to-back traffic
    for (int t = 0; t < 400; t++) begin
      bus_if.vld_i   = ($urandom_range(0, 9) < 7);
      bus_if.data_i  = DATA_W'($urandom);
      bus_if.flush_i = ($urandom_range(0, 9) == 0);
      bus_if.rdy_i   = ($urandom_range(0, 9) < 6);
      cycle();
    end
    bus_if.vld_i   = 1'b0;
    bus_if.flush_i = 1'b0;
    drain(20);
    if (cur_q.size() != 0) send(8'd0, 1'b1);
    drain(20);

    // Reset while a block is pending in OUT
    bus_if.rdy_i = 1'b0;
    for (int i = 0; i < 8; i++) send(DATA_W'($urandom), 1'b0);
    check_eq("rst_out_pre_vld", bus_if.vld_o, 1);
    do_reset();
    bus_if.rdy_i = 1'b1;

    // Reset mid-block, then a clean full block
    for (int i = 0; i < 4; i++) send(DATA_W'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) send(DATA_W'(i * 3 + 1), 1'b0);
    check_eq("post_rst_base", bus_if.dbp_block_o.base, 1);
    drain(20);
    check_eq("end_idle", bus_if.idle_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
